moore_seq_fsm: RTL and testbench

Parametrised Moore sequencer, the successor to the team's fixed 4-state Moore FSM. It walks a state sequence defined by a parameter next-state table, advancing only when x is high and the minimum dwell time in the current state has expired. It adds a direct state load, a one-hot match output, a wrap pulse and a load-error flag. It sits in the control path as a step/phase generator for datapath blocks.

---
 rtl/moore_seq_fsm_pkg.sv | 42 ++++
 rtl/fsm_dwell_counter.sv | 37 +++
 rtl/moore_seq_fsm.sv | 116 +++++++++++
 tb/tb_moore_seq_fsm.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/moore_seq_fsm_pkg.sv
// Shared constants, action codes and table lookup helper
// for the parametrised Moore step sequencer.
package moore_seq_fsm_pkg;

    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;
    localparam logic [1:0] S3 = 2'd3;

    // Slice s is the successor of s: 0->2, 1->0, 2->3, 3->1.
    localparam logic [7:0] DEF_NEXT_TABLE = {S1, S3, S0, S2};

    localparam int MAX_SW    = 8;
    localparam int MAX_TBL_W = 2048;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_ADV
    } act_e;

    function automatic logic [MAX_SW-1:0] next_of(
        input logic [MAX_TBL_W-1:0] tbl,
        input int                   s,
        input int                   sw,
        input int                   n
    );
        logic [MAX_SW-1:0] r;
        r = '0;
        for (int b = 0; b < MAX_SW; b++) begin
            if (b < sw && (s * sw + b) < MAX_TBL_W) begin
                r[b] = tbl[s * sw + b];
            end
        end
        // Out-of-range successors collapse to state 0.
        if (int'(r) >= n) begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fsm_dwell_counter.sv
// Minimum-dwell down counter: reloads on state entry,
// then counts down and saturates at zero.
module fsm_dwell_counter #(
    parameter int DWELL_W = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               reload_i,
    input  logic [DWELL_W-1:0] val_i,
    output logic               zero_o,
    output logic               busy_o
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (reload_i) begin
            cnt_d = val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign busy_o = ~zero_o;

endmodule

// File: rtl/moore_seq_fsm.sv
// Table-driven Moore step/phase sequencer with minimum dwell,
// direct load, wrap pulse and sticky load-error flag.
module moore_seq_fsm
    import moore_seq_fsm_pkg::*;
#(
    parameter int STATE_W    = 2,
    parameter int NUM_STATES = 4,
    parameter logic [NUM_STATES*STATE_W-1:0] NEXT_TABLE =
        DEF_NEXT_TABLE,
    parameter int OUT_STATE  = 3,
    parameter int DWELL_W    = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               x,
    input  logic               load,
    input  logic [STATE_W-1:0] load_state,
    input  logic [DWELL_W-1:0] dwell,
    output logic [STATE_W-1:0] state,
    output logic               y,
    output logic               wrap,
    output logic               busy,
    output logic               err
);

    localparam logic [MAX_TBL_W-1:0] TBL_EXT =
        MAX_TBL_W'(NEXT_TABLE);

    logic [STATE_W-1:0] state_q, state_d, nxt;
    logic               y_q, y_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;
    logic               reload, cnt_zero;
    act_e               act;

    assign nxt = STATE_W'(next_of(TBL_EXT, int'(state_q),
                                  STATE_W, NUM_STATES));

    fsm_dwell_counter #(
        .DWELL_W (DWELL_W)
    ) u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .reload_i (reload),
        .val_i    (dwell),
        .zero_o   (cnt_zero),
        .busy_o   (busy)
    );

    always_comb begin
        act = ACT_HOLD;
        if (load) begin
            act = ACT_LOAD;
        end else if (x && cnt_zero) begin
            act = ACT_ADV;
        end
    end

    always_comb begin
        state_d = state_q;
        wrap_d  = 1'b0;
        err_d   = err_q;
        reload  = 1'b0;
        unique case (act)
            ACT_LOAD: begin
                reload = 1'b1;
                if (int'(load_state) < NUM_STATES) begin
                    state_d = load_state;
                end else begin
                    state_d = '0;
                    err_d   = 1'b1;
                end
            end
            ACT_ADV: begin
                reload  = 1'b1;
                state_d = nxt;
                wrap_d  = (nxt == '0);
            end
            default: ;
        endcase
        // y is decoded from the next state so it lands with it.
        y_d = (int'(state_d) == OUT_STATE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            y_q     <= (OUT_STATE == 0);
        end else begin
            state_q <= state_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            y_q     <= y_d;
        end
    end

`ifndef SYNTHESIS
    logic [STATE_W-1:0] raw_nxt;
    assign raw_nxt =
        NEXT_TABLE[int'(state_q)*STATE_W +: STATE_W];

    always @(posedge CLK) begin
        if (!RST && act == ACT_ADV) begin
            assert (int'(raw_nxt) < NUM_STATES);
        end
    end
`endif

    assign state = state_q;
    assign y     = y_q;
    assign wrap  = wrap_q;
    assign err   = err_q;

endmodule

// File: tb/tb_moore_seq_fsm.sv
// Randomised bench for moore_seq_fsm: default 4-state instance
// plus a 3-state instance, both against a behavioural model.
module tb_moore_seq_fsm;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       x = 1'b0;
    logic       load = 1'b0;
    logic [1:0] ls = 2'd0;
    logic [3:0] dw = 4'd0;

    logic [1:0] sa, sb;
    logic       ya, wa, ba, ea;
    logic       yb, wb, bb, eb;

    always #5 CLK = ~CLK;

    moore_seq_fsm u_a (
        .CLK        (CLK),
        .RST        (RST),
        .x          (x),
        .load       (load),
        .load_state (ls),
        .dwell      (dw),
        .state      (sa),
        .y          (ya),
        .wrap       (wa),
        .busy       (ba),
        .err        (ea)
    );

    moore_seq_fsm #(
        .STATE_W    (2),
        .NUM_STATES (3),
        .NEXT_TABLE (6'b00_10_01),
        .OUT_STATE  (3),
        .DWELL_W    (4)
    ) u_b (
        .CLK        (CLK),
        .RST        (RST),
        .x          (x),
        .load       (load),
        .load_state (ls),
        .dwell      (dw),
        .state      (sb),
        .y          (yb),
        .wrap       (wb),
        .busy       (bb),
        .err        (eb)
    );

    typedef struct {
        int st;
        int cnt;
        bit wrap;
        bit err;
    } mdl_t;

    mdl_t ma, mb;
    int   tbl_a[4] = '{2, 0, 3, 1};
    int   tbl_b[4] = '{1, 2, 0, 0};
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(string tag, logic [31:0] obs,
                       logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, obs, exp);
        end
    endtask

    function automatic mdl_t step(mdl_t m, bit r, bit xx,
                                  bit ld, int l, int d,
                                  int ns, int tbl[4]);
        mdl_t n = m;
        if (r) begin
            n.st = 0; n.cnt = 0; n.wrap = 0; n.err = 0;
            return n;
        end
        n.wrap = 0;
        if (ld) begin
            if (l < ns) n.st = l;
            else begin n.st = 0; n.err = 1; end
            n.cnt = d;
        end else if (xx && m.cnt == 0) begin
            n.st   = (tbl[m.st] < ns) ? tbl[m.st] : 0;
            n.cnt  = d;
            n.wrap = (n.st == 0);
        end else if (m.cnt > 0) begin
            n.cnt = m.cnt - 1;
        end
        return n;
    endfunction

    task automatic cyc(bit r, bit xx, bit ld, int l, int d);
        RST = r; x = xx; load = ld;
        ls = l[1:0]; dw = d[3:0];
        @(posedge CLK);
        ma = step(ma, r, xx, ld, l, d, 4, tbl_a);
        mb = step(mb, r, xx, ld, l, d, 3, tbl_b);
        #1;
        chk("a_state", sa, ma.st);
        chk("a_y", ya, ma.st == 3);
        chk("a_wrap", wa, ma.wrap);
        chk("a_busy", ba, ma.cnt != 0);
        chk("a_err", ea, ma.err);
        chk("b_state", sb, mb.st);
        chk("b_y", yb, mb.st == 3);
        chk("b_wrap", wb, mb.wrap);
        chk("b_busy", bb, mb.cnt != 0);
        chk("b_err", eb, mb.err);
    endtask

    int seq_st[5]   = '{2, 3, 1, 0, 2};
    int pat_x[4]    = '{1, 0, 0, 1};
    int pat_st[4]   = '{2, 2, 2, 3};
    int dw_st[7]    = '{2, 2, 2, 3, 3, 3, 1};
    int dw_busy[7]  = '{1, 1, 0, 1, 1, 0, 1};

    initial begin
        ma = '{0, 0, 0, 0};
        mb = '{0, 0, 0, 0};

        cyc(1, 0, 0, 0, 0);
        chk("rst_state", sa, 0);
        chk("rst_y", ya, 0);

        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 0, 0);
            chk("seq_state", sa, seq_st[i]);
            chk("seq_y", ya, i == 1);
            chk("seq_wrap", wa, i == 3);
        end

        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, pat_x[i][0], 0, 0, 0);
            chk("xpat_state", sa, pat_st[i]);
        end

        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 1, 0, 0, 2);
            chk("dwell_state", sa, dw_st[i]);
            chk("dwell_busy", ba, dw_busy[i]);
        end

        cyc(0, 1, 1, 1, 3);
        chk("ldx_state", sa, 1);
        chk("ldx_busy", ba, 1);
        chk("ldx_wrap", wa, 0);

        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 3, 0);
        chk("bad_ld_state", sb, 0);
        chk("bad_ld_err", eb, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0, 0);
            chk("err_sticky", eb, 1);
        end

        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 5);
        cyc(0, 0, 0, 0, 5);
        cyc(0, 0, 0, 0, 5);
        cyc(1, 0, 0, 0, 5);
        chk("mid_rst_state", sa, 0);
        chk("mid_rst_busy", ba, 0);
        chk("mid_rst_y", ya, 0);
        cyc(0, 1, 0, 0, 0);
        chk("resume_state", sa, 2);

        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 49) == 0,
                $urandom_range(0, 9) < 7,
                $urandom_range(0, 7) == 0,
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks",
                 n_err, n_chk);
        $finish;
    end

endmodule
